bcp_mem_arbiter: RTL

BCP_MEM_ARBITER -- requirements
Module: bcp_mem_arbiter

---
 rtl/bcp_mem_arbiter.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/bcp_mem_arbiter.sv
// -----------------------------------------------------------------------------
// bcp_mem_arbiter
//
// Round-robin arbiter that shares one variable-table memory port between
// several requesters (0 = BCP, 1 = conflict analysis, 2 = select_var). A winner
// is picked in IDLE. Its command is latched and replayed on the memory port
// during ACCESS. A one-cycle RELEASE gap then returns the block to IDLE. An
// 8-bit watchdog ends an ACCESS that never sees mem_finish and raises a sticky
// error flag. Every output comes from a register.
//
// Handshake: a requester raises req_i[i] (a level) and holds it, together with
// its write/address/wdata slices, until done_o[i] pulses for one cycle. Grant
// and done are never high in the same cycle. On the memory side, mem_request_o
// stays high for the whole transaction. The memory answers with a single-cycle
// mem_finish_i, and mem_rdata_i is valid in that same cycle.
//
// Ports
//   clock_i          clock, all logic on posedge
//   reset_i          synchronous reset, active low
//   req_i            per-requester request level
//   req_write_i      per-requester direction (1 = write)
//   req_address_i    per-requester address, slice i for requester i
//   req_wdata_i      per-requester write data, slice i for requester i
//   grant_o          one-hot owner of the memory port
//   done_o           one-cycle completion pulse to the owner
//   rdata_o          read data, valid while done_o is high (held otherwise)
//   mem_request_o    memory transaction in flight
//   mem_read_o       memory read strobe
//   mem_write_o      memory write strobe
//   mem_address_o    memory address
//   mem_wdata_o      memory write data
//   mem_rdata_i      memory read data, valid with mem_finish_i
//   mem_finish_i     memory access complete pulse
//   busy_o           high whenever the FSM is not in IDLE
//   timeout_error_o  sticky watchdog-expiry flag, cleared only by reset
//   state_o          current FSM state (debug)
// -----------------------------------------------------------------------------
module bcp_mem_arbiter #(
  parameter int num_req                = 3,
  parameter int var_table_address_size = 3,
  parameter int data_width             = 8,
  parameter int timeout_cycles         = 15
) (
  input  logic                                      clock_i,
  input  logic                                      reset_i,
  input  logic [num_req-1:0]                        req_i,
  input  logic [num_req-1:0]                        req_write_i,
  input  logic [num_req*var_table_address_size-1:0] req_address_i,
  input  logic [num_req*data_width-1:0]             req_wdata_i,
  output logic [num_req-1:0]                        grant_o,
  output logic [num_req-1:0]                        done_o,
  output logic [data_width-1:0]                     rdata_o,
  output logic                                      mem_request_o,
  output logic                                      mem_read_o,
  output logic                                      mem_write_o,
  output logic [var_table_address_size-1:0]         mem_address_o,
  output logic [data_width-1:0]                     mem_wdata_o,
  input  logic [data_width-1:0]                     mem_rdata_i,
  input  logic                                      mem_finish_i,
  output logic                                      busy_o,
  output logic                                      timeout_error_o,
  output logic [1:0]                                state_o
);

  localparam int AW = var_table_address_size;
  localparam int DW = data_width;
  localparam int PW = (num_req > 1) ? $clog2(num_req) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_RELEASE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [7:0]         wd_q, wd_d;
  logic [num_req-1:0] grant_q, grant_d;
  logic [num_req-1:0] done_q, done_d;
  logic [DW-1:0]      rdata_q, rdata_d;
  logic               mem_request_q, mem_request_d;
  logic               mem_read_q, mem_read_d;
  logic               mem_write_q, mem_write_d;
  logic [AW-1:0]      mem_address_q, mem_address_d;
  logic [DW-1:0]      mem_wdata_q, mem_wdata_d;
  logic               busy_q, busy_d;
  logic               timeout_error_q, timeout_error_d;

  // Arbitration results, valid while in IDLE.
  logic               win_found;
  logic [PW-1:0]      winner;
  logic [PW:0]        arb_sum;
  logic [PW-1:0]      arb_sel;
  logic [num_req-1:0] win_onehot;
  logic               win_write;
  logic [AW-1:0]      win_addr;
  logic [DW-1:0]      win_wdata;
  logic               wd_expire;

  // Search upward from rr_ptr with wrap. The first set request wins.
  always_comb begin
    win_found = 1'b0;
    winner    = '0;
    arb_sum   = '0;
    arb_sel   = '0;
    for (int k = 0; k < num_req; k++) begin
      arb_sum = {1'b0, rr_ptr_q} + (PW+1)'(k);
      if (arb_sum >= (PW+1)'(num_req)) begin
        arb_sum = arb_sum - (PW+1)'(num_req);
      end
      arb_sel = arb_sum[PW-1:0];
      if (!win_found && req_i[arb_sel]) begin
        win_found = 1'b1;
        winner    = arb_sel;
      end
    end
  end

  // Pull out the winner's command slices using constant part-selects.
  always_comb begin
    win_onehot = '0;
    win_write  = 1'b0;
    win_addr   = '0;
    win_wdata  = '0;
    for (int i = 0; i < num_req; i++) begin
      if (winner == PW'(i)) begin
        win_onehot[i] = 1'b1;
        win_write     = req_write_i[i];
        win_addr      = req_address_i[i*AW +: AW];
        win_wdata     = req_wdata_i[i*DW +: DW];
      end
    end
  end

  // wd_q counts completed ACCESS cycles. It expires in the cycle that would
  // bring the count to timeout_cycles. A mem_finish in that same cycle takes
  // priority over the expiry.
  assign wd_expire = ({1'b0, wd_q} + 9'd1) == 9'(timeout_cycles);

  // State register and all output registers.
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q         <= S_IDLE;
      rr_ptr_q        <= '0;
      wd_q            <= '0;
      grant_q         <= '0;
      done_q          <= '0;
      rdata_q         <= '0;
      mem_request_q   <= 1'b0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_address_q   <= '0;
      mem_wdata_q     <= '0;
      busy_q          <= 1'b0;
      timeout_error_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      rr_ptr_q        <= rr_ptr_d;
      wd_q            <= wd_d;
      grant_q         <= grant_d;
      done_q          <= done_d;
      rdata_q         <= rdata_d;
      mem_request_q   <= mem_request_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      mem_address_q   <= mem_address_d;
      mem_wdata_q     <= mem_wdata_d;
      busy_q          <= busy_d;
      timeout_error_q <= timeout_error_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (win_found) state_d = S_ACCESS;
      S_ACCESS:  if (mem_finish_i || wd_expire) state_d = S_RELEASE;
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output logic. It computes the next value of every registered output.
  always_comb begin
    grant_d         = grant_q;
    done_d          = '0;
    rdata_d         = rdata_q;
    mem_request_d   = mem_request_q;
    mem_read_d      = mem_read_q;
    mem_write_d     = mem_write_q;
    mem_address_d   = mem_address_q;
    mem_wdata_d     = mem_wdata_q;
    timeout_error_d = timeout_error_q;
    rr_ptr_d        = rr_ptr_q;
    wd_d            = wd_q;
    busy_d          = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: begin
        grant_d       = '0;
        mem_request_d = 1'b0;
        mem_read_d    = 1'b0;
        mem_write_d   = 1'b0;
        if (win_found) begin
          grant_d       = win_onehot;
          mem_request_d = 1'b1;
          mem_read_d    = !win_write;
          mem_write_d   = win_write;
          mem_address_d = win_addr;
          mem_wdata_d   = win_wdata;
          rr_ptr_d      = (winner == PW'(num_req - 1)) ? '0 : winner + PW'(1);
          wd_d          = '0;
        end
      end
      S_ACCESS: begin
        if (mem_finish_i || wd_expire) begin
          done_d        = grant_q;
          grant_d       = '0;
          mem_request_d = 1'b0;
          mem_read_d    = 1'b0;
          mem_write_d   = 1'b0;
          if (mem_finish_i) begin
            // mem_read_q holds the latched direction for the whole ACCESS.
            if (mem_read_q) rdata_d = mem_rdata_i;
          end else begin
            timeout_error_d = 1'b1;
          end
        end else begin
          wd_d = wd_q + 8'd1;
        end
      end
      default: begin
        grant_d       = '0;
        mem_request_d = 1'b0;
        mem_read_d    = 1'b0;
        mem_write_d   = 1'b0;
      end
    endcase
  end

  assign grant_o         = grant_q;
  assign done_o          = done_q;
  assign rdata_o         = rdata_q;
  assign mem_request_o   = mem_request_q;
  assign mem_read_o      = mem_read_q;
  assign mem_write_o     = mem_write_q;
  assign mem_address_o   = mem_address_q;
  assign mem_wdata_o     = mem_wdata_q;
  assign busy_o          = busy_q;
  assign timeout_error_o = timeout_error_q;
  assign state_o         = state_q;

endmodule
